// File: rtl/pipe_mux_stage_pkg.sv
// Shared processor definitions: default datapath width and the skid-stage
// state encoding used by pipe_mux_stage.
package pipe_mux_stage_pkg;

    localparam int XLEN = 32;

    // Bit 0 = main register valid, bit 1 = skid register valid.
    typedef logic [1:0] state_t;
    localparam state_t ST_EMPTY = 2'b00;
    localparam state_t ST_BUSY  = 2'b01;
    localparam state_t ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_mux_stage_mux_n.sv
// Combinational N:1 selector with out-of-range detection; an out-of-range
// select yields all-zero data and err = 1.
module mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] data,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   y,
    output logic               err
);

    always_comb begin
        y   = '0;
        err = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                y   = data[k*WIDTH +: WIDTH];
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_mux_stage.sv
// N:1 operand select launched through a two-entry skid buffer with
// registered in_ready, flush, and a saturating stall counter.
module pipe_mux_stage import pipe_mux_stage_pkg::*; #(
    parameter int WIDTH = XLEN,
    parameter int N     = 4,
    parameter int CNTW  = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sel_err,
    input  logic               flush,
    output logic [CNTW-1:0]    stall_cnt
);

    state_t            st, st_nxt;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_err;
    logic [WIDTH-1:0]  skid_data;
    logic              skid_err;
    logic              accept, xfer;
    logic              load_main, load_skid, main_from_skid;

    mux_n #(.WIDTH(WIDTH), .N(N)) u_mux (
        .data (in_data),
        .sel  (in_sel),
        .y    (sel_data),
        .err  (sel_err)
    );

    // Valid flags are the state bits themselves, so in_ready has no
    // combinational dependence on out_ready.
    assign out_valid = st[0];
    assign in_ready  = ~st[1];
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) st <= ST_EMPTY;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (flush) begin
            st_nxt = ST_EMPTY;
        end else begin
            case (st)
                ST_EMPTY: if (accept) st_nxt = ST_BUSY;
                ST_BUSY: begin
                    if (accept && !xfer)      st_nxt = ST_FULL;
                    else if (!accept && xfer) st_nxt = ST_EMPTY;
                end
                ST_FULL:  if (xfer) st_nxt = ST_BUSY;
                default:  st_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            case (st)
                ST_EMPTY: load_main = accept;
                ST_BUSY: begin
                    load_main = accept & xfer;
                    load_skid = accept & ~xfer;
                end
                ST_FULL:  main_from_skid = xfer;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data    <= '0;
            out_sel_err <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else begin
            if (load_main) begin
                out_data    <= sel_data;
                out_sel_err <= sel_err;
            end else if (main_from_skid) begin
                out_data    <= skid_data;
                out_sel_err <= skid_err;
            end
            if (load_skid) begin
                skid_data <= sel_data;
                skid_err  <= sel_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush || xfer)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNTW{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
